// File: rtl/oka_pkg.sv
// Shared definitions for the overlap-combine accumulator and the Karatsuba tree built on it.
package oka_pkg;

   localparam logic [1:0] TERM_EE = 2'd0;
   localparam logic [1:0] TERM_EO = 2'd1;
   localparam logic [1:0] TERM_OE = 2'd2;
   localparam logic [1:0] TERM_OO = 2'd3;

   typedef enum logic {
      COLLECT = 1'b0,
      DONE    = 1'b1
   } oka_state_e;

   // Product width for PW-bit sub-product terms.
   function automatic int unsigned ow_of(input int unsigned pw);
      return 2 * pw + 1;
   endfunction

endpackage

// File: rtl/overlap_spread.sv
// Spreads one sub-product term onto even/odd/shifted-even bit positions of the product.
module overlap_spread
   import oka_pkg::*;
#(
   parameter  int unsigned PW = 15,
   localparam int unsigned OW = ow_of(PW)
) (
   input  logic [1:0]    sel,
   input  logic [PW-1:0] data,
   output logic [OW-1:0] spread
);

   always_comb begin
      spread = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         case (sel)
            TERM_EE:          spread[2*i]   = data[i];
            TERM_EO, TERM_OE: spread[2*i+1] = data[i];
            TERM_OO:          spread[2*i+2] = data[i];
         endcase
      end
   end

endmodule

// File: rtl/overlap_accum_seq.sv
// Collects the four overlap terms in any order, XOR-accumulates them and presents the product.
module overlap_accum_seq
   import oka_pkg::*;
#(
   parameter  int unsigned PW = 15,
   localparam int unsigned OW = ow_of(PW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_sel,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          err_dup
);

   oka_state_e    state_q;
   logic [OW-1:0] acc_q;
   logic [OW-1:0] acc_d;
   logic [3:0]    mask_q;
   logic [3:0]    mask_d;
   logic          in_ready_q;
   logic          out_valid_q;
   logic [OW-1:0] out_data_q;
   logic          err_dup_q;
   logic [OW-1:0] spread;
   logic          accept;
   logic          dup;

   overlap_spread #(.PW(PW)) u_spread (
      .sel    (in_sel),
      .data   (in_data),
      .spread (spread)
   );

   always_comb begin
      accept = in_valid && in_ready_q;
      dup    = mask_q[in_sel];
      mask_d = mask_q | (4'(1) << in_sel);
      acc_d  = acc_q ^ spread;
   end

   // A repeated index is consumed but only flagged; the frame completes on the fourth distinct term.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         acc_q       <= '0;
         mask_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         err_dup_q   <= 1'b0;
      end else begin
         err_dup_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  if (dup) begin
                     err_dup_q <= 1'b1;
                  end else begin
                     acc_q  <= acc_d;
                     mask_q <= mask_d;
                     if (&mask_d) begin
                        state_q     <= DONE;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d;
                     end
                  end
               end
            end
            DONE: begin
               // No bypass: the next frame starts accepting one cycle after the handshake.
               if (out_ready) begin
                  state_q     <= COLLECT;
                  acc_q       <= '0;
                  mask_q      <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
               end
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign err_dup   = err_dup_q;

endmodule

// File: doc/overlap_accum_seq.md
OVERLAP_ACCUM_SEQ -- requirements
Module: overlap_accum_seq

Interface
REQ-001 SHALL have parameter PW, default 15, giving the width of each sub-product term in bits.
REQ-002 SHALL have derived localparam OW = 2*PW+1, giving the width of the assembled product in bits.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, all state updating on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit; a term is offered.
REQ-006 SHALL have port in_ready, output, 1 bit; the block can accept a term.
REQ-007 SHALL have port in_sel, input, 2 bits; term index: 0 = even*even, 1 = even*odd, 2 = odd*even, 3 = odd*odd.
REQ-008 SHALL have port in_data, input, PW bits; the term value.
REQ-009 SHALL have port out_valid, output, 1 bit; the assembled product is available.
REQ-010 SHALL have port out_ready, input, 1 bit; the consumer accepts the product.
REQ-011 SHALL have port out_data, output, OW bits; the assembled product.
REQ-012 SHALL have port err_dup, output, 1 bit; one-cycle pulse when a term index is repeated within a frame.

Function
REQ-013 SHALL implement two states: COLLECT and DONE.
REQ-014 SHALL drive in_ready = 1 exactly when state is COLLECT; out_valid = 1 exactly when state is DONE.
REQ-015 SHALL accept a term when in_valid and in_ready are both 1 in the same cycle.
REQ-016 SHALL map an accepted term k into the accumulator as follows, for i = 0..PW-1:
  - sel 0: bit 2i
  - sel 1 and sel 2: bit 2i+1
  - sel 3: bit 2i+2
REQ-017 SHALL XOR each mapped term into the OW-bit accumulator (GF(2) addition; no carries).
REQ-018 SHALL leave accumulator bit OW-1 (2*PW) driven only by sel 3, bit PW-1.
REQ-019 SHALL track accepted terms in a 4-bit mask and set bit in_sel on each accepted term.
REQ-020 SHALL treat a term whose mask bit is already set as a duplicate:
  - the term is consumed (in_ready stays 1);
  - the accumulator and mask are unchanged;
  - err_dup pulses high for exactly one cycle.
REQ-021 SHALL enter DONE on the clock edge that accepts the fourth distinct term, so out_valid rises one cycle after that acceptance.
REQ-022 SHALL hold out_data stable, equal to the accumulator, while in DONE.
REQ-023 SHALL return to COLLECT on an out_valid && out_ready cycle, clearing the accumulator and the mask to zero on that same edge.
REQ-024 SHALL NOT accept a term in the cycle the output is consumed; in_ready rises the following cycle (no bypass).
REQ-025 SHALL accept terms in any order, with any number of idle cycles between them.
REQ-026 SHALL drive out_data to zero whenever the state is COLLECT.
REQ-027 SHALL give the result for PW = 15 that is bit-identical to the combinational overlap combine of the same four terms.

Reset
REQ-028 SHALL, while rst = 1, force:
  - state to COLLECT;
  - the accumulator and mask to 0;
  - in_ready = 0, out_valid = 0, out_data = 0, err_dup = 0.
REQ-029 SHALL, when rst is asserted mid-frame or in DONE, discard any partial or pending product without emitting it.
REQ-030 SHALL raise in_ready in the first cycle after rst deasserts.

Structure
REQ-031 SHALL place the following in shared package oka_pkg, reused by the future multi-level Karatsuba tree:
  - the term-index localparams TERM_EE, TERM_EO, TERM_OE, TERM_OO;
  - the state enum;
  - a function returning OW from PW.
REQ-032 SHALL place the combinational bit-spreading of REQ-016 in a sub-module named overlap_spread (parameter PW; inputs sel and data; output OW bits), instantiated once.

Verification
REQ-033 SHALL cover: PW = 15; sel 0 = 15'h0001, sel 3 = 15'h4000, sel 1 = sel 2 = 15'h7FFF, back-to-back -> out_valid one cycle after the fourth accept; out_data = 31'h40000001.
REQ-034 SHALL cover: the same four terms offered in order 3, 1, 0, 2 with two idle cycles between each -> identical out_data 31'h40000001.
REQ-035 SHALL cover: sel 0 = 15'h0001, then a repeat of sel 0 = 15'h0003 -> err_dup pulses for one cycle, mask is unchanged; after the remaining terms (all zero) out_data = 31'h00000001.
REQ-036 SHALL cover: out_ready held at 0 for 5 cycles in DONE -> out_data stable, in_ready = 0; on the handshake cycle the accumulator clears; in_ready = 1 on the next cycle.
REQ-037 SHALL cover: rst pulsed after two terms are accepted -> no out_valid; a following full frame with sel 1 = 15'h0001 and all other terms zero -> out_data = 31'h00000002.
REQ-038 SHALL cover: 1000 random frames at PW = 15 and PW = 7 -> out_data equals the reference model of REQ-016/017, and err_dup never fires unless a duplicate is injected.
